// File: rtl/multiboot_pkg.sv
// multiboot_pkg: ICAP command words, sequencer state type and the per-byte bit reversal used on icap_i.
package multiboot_pkg;
  localparam logic [15:0] SYNC1     = 16'hAA99;
  localparam logic [15:0] SYNC2     = 16'h5566;
  localparam logic [15:0] WR_CMD    = 16'h30A1;
  localparam logic [15:0] WR_GEN1   = 16'h3261;
  localparam logic [15:0] WR_GEN2   = 16'h3281;
  localparam logic [15:0] WR_GEN3   = 16'h32A1;
  localparam logic [15:0] WR_GEN4   = 16'h32C1;
  localparam logic [15:0] CMD_IPROG = 16'h000E;
  localparam logic [15:0] NOOP      = 16'h2000;
  localparam logic [15:0] DUMMY     = 16'hFFFF;
  localparam logic [15:0] END_WORD  = 16'h1111;
  typedef enum logic [1:0] {IDLE, SEQ, DONE} state_t;
  // ICAP_SPARTAN6 expects each byte of the word with its bits mirrored.
  function automatic logic [15:0] byte_reverse(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8+i]   = w[15-i];
    end
    return r;
  endfunction
endpackage

// File: rtl/multiboot_icap_seq.sv
// multiboot_icap_seq: divided ICAP clock plus the IPROG word sequencer.
//   start      level request; sampled at each sequencer strobe while IDLE
//   addr       24-bit boot address written to GENERAL_1/2
//   icap_clk   ICAP clock, ICAP_DIV clk cycles per period
//   icap_ce_n / icap_wr_n / icap_i  registered ICAP pins (icap_i already bit-swapped)
//   done       one-cycle pulse when the sequence returns to IDLE
module multiboot_icap_seq
  import multiboot_pkg::*;
#(
  parameter int          ICAP_DIV    = 4,
  parameter bit          GOLDEN_EN   = 1'b1,
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
  parameter logic [7:0]  READ_OPCODE = 8'h03
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  output logic        icap_clk,
  output logic        icap_ce_n,
  output logic        icap_wr_n,
  output logic [15:0] icap_i,
  output logic        done
);
  localparam int HALF = ICAP_DIV / 2;
  localparam int HW = $clog2(HALF + 1);
  localparam logic [4:0] LAST = GOLDEN_EN ? 5'd17 : 5'd13;
  logic [HW-1:0] cnt;
  logic [4:0] idx, j;
  logic [15:0] word;
  logic strobe, half_end;
  state_t state;
  assign half_end = cnt == HW'(HALF - 1);
  // Everything advances as icap_clk falls, giving half a period of setup before ICAP samples.
  assign strobe = icap_clk && half_end;
  // Without the golden block the tail words sit directly after word 7.
  assign j = (!GOLDEN_EN && idx >= 5'd8) ? idx + 5'd4 : idx;
  always_comb begin
    word = DUMMY;
    case (j)
      5'd0:  word = SYNC1;
      5'd1:  word = SYNC2;
      5'd2:  word = WR_CMD;
      5'd3:  word = 16'h0000;
      5'd4:  word = WR_GEN1;
      5'd5:  word = addr[15:0];
      5'd6:  word = WR_GEN2;
      5'd7:  word = {READ_OPCODE, addr[23:16]};
      5'd8:  word = WR_GEN3;
      5'd9:  word = GOLDEN_ADDR[15:0];
      5'd10: word = WR_GEN4;
      5'd11: word = {READ_OPCODE, GOLDEN_ADDR[23:16]};
      5'd12: word = WR_CMD;
      5'd13: word = CMD_IPROG;
      5'd14, 5'd15, 5'd16, 5'd17: word = NOOP;
      default: word = DUMMY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      icap_clk  <= 1'b0;
      state     <= IDLE;
      idx       <= '0;
      icap_ce_n <= 1'b1;
      icap_wr_n <= 1'b1;
      icap_i    <= byte_reverse(DUMMY);
      done      <= 1'b0;
    end else begin
      cnt  <= half_end ? '0 : cnt + 1'b1;
      done <= strobe && state == DONE;
      if (half_end) icap_clk <= ~icap_clk;
      if (strobe) begin
        case (state)
          IDLE: if (start) begin
            state     <= SEQ;
            idx       <= 5'd1;
            icap_ce_n <= 1'b0;
            icap_wr_n <= 1'b0;
            icap_i    <= byte_reverse(word);
          end
          SEQ: if (idx > LAST) begin
            state     <= DONE;
            icap_ce_n <= 1'b1;
            icap_wr_n <= 1'b1;
            icap_i    <= byte_reverse(END_WORD);
          end else begin
            idx    <= idx + 5'd1;
            icap_i <= byte_reverse(word);
          end
          default: begin
            state  <= IDLE;
            idx    <= '0;
            icap_i <= byte_reverse(DUMMY);
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/multiboot_icap_ctrl.sv
// multiboot_icap_ctrl: register-programmable Spartan-6 multiboot controller driving an external ICAP.
//   zxuno_addr/regwr/regrd/din  register bus; writes act once per regwr rising edge
//   dout/oe                     combinational readback
//   kb_boot_core                asynchronous keyboard boot request (level)
//   busy                        IPROG sequence in progress
//   icap_clk/ce_n/wr_n/i        to ICAP_SPARTAN6
module multiboot_icap_ctrl
  import multiboot_pkg::*;
#(
  parameter logic [7:0]  ADDR_COREADDR = 8'hFC,
  parameter logic [7:0]  ADDR_COREBOOT = 8'hFD,
  parameter logic [23:0] DEFAULT_ADDR  = 24'h0AC000,
  parameter bit          GOLDEN_EN     = 1'b1,
  parameter logic [23:0] GOLDEN_ADDR   = 24'h000000,
  parameter logic [7:0]  READ_OPCODE   = 8'h03,
  parameter int          ICAP_DIV      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kb_boot_core,
  input  logic [7:0]  zxuno_addr,
  input  logic        zxuno_regwr,
  input  logic        zxuno_regrd,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe,
  output logic        busy,
  output logic        icap_clk,
  output logic        icap_ce_n,
  output logic        icap_wr_n,
  output logic [15:0] icap_i
);
  logic [23:0] spi_addr, shadow_addr;
  logic [2:0] kb_s;
  logic regwr_q, wr_rise, wr_addr, wr_boot, kb_rise, trig, done;
  assign wr_rise = zxuno_regwr && !regwr_q;
  assign wr_addr = wr_rise && !busy && zxuno_addr == ADDR_COREADDR;
  assign wr_boot = wr_rise && !busy && zxuno_addr == ADDR_COREBOOT;
  assign kb_rise = kb_s[1] && !kb_s[2];
  assign trig = !busy && ((wr_boot && din[0]) || kb_rise);
  assign oe = zxuno_regrd && (zxuno_addr == ADDR_COREBOOT || zxuno_addr == ADDR_COREADDR);
  assign dout = !zxuno_regrd ? 8'h00 :
                zxuno_addr == ADDR_COREBOOT ? {busy, 6'b0, GOLDEN_EN} :
                zxuno_addr == ADDR_COREADDR ? spi_addr[7:0] : 8'h00;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi_addr    <= DEFAULT_ADDR;
      shadow_addr <= DEFAULT_ADDR;
      regwr_q     <= 1'b0;
      kb_s        <= '0;
      busy        <= 1'b0;
    end else begin
      regwr_q <= zxuno_regwr;
      kb_s    <= {kb_s[1:0], kb_boot_core};
      if (wr_addr) spi_addr <= {spi_addr[15:0], din};
      else if (wr_boot && din[7]) spi_addr <= DEFAULT_ADDR;
      // Clear-and-boot in one write must boot from the default address.
      if (trig) begin
        busy        <= 1'b1;
        shadow_addr <= (wr_boot && din[7]) ? DEFAULT_ADDR : spi_addr;
      end else if (done) busy <= 1'b0;
    end
  end
  multiboot_icap_seq #(
    .ICAP_DIV(ICAP_DIV), .GOLDEN_EN(GOLDEN_EN),
    .GOLDEN_ADDR(GOLDEN_ADDR), .READ_OPCODE(READ_OPCODE)
  ) u_seq (
    .clk(clk), .rst_n(rst_n), .start(busy), .addr(shadow_addr),
    .icap_clk(icap_clk), .icap_ce_n(icap_ce_n), .icap_wr_n(icap_wr_n),
    .icap_i(icap_i), .done(done)
  );
endmodule

// File: tb/tb_multiboot_icap_ctrl.sv
// tb_multiboot_icap_ctrl: scoreboard bench driving a golden-less and a golden-enabled controller in parallel.
module tb_multiboot_icap_ctrl;
  localparam int DIV = 4;
  logic clk = 1'b0, rst_n = 1'b0, kb = 1'b0, regwr = 1'b0, regrd = 1'b0;
  logic [7:0] addr = 8'h00, din = 8'h00;
  logic [7:0] dout0, dout1;
  logic oe0, oe1, busy0, busy1, ick0, ick1, ce0, ce1, wr0, wr1;
  logic [15:0] i0, i1;
  logic [15:0] q0[$], q1[$];
  int total = 0, pass = 0, popped0 = 0;
  always #5 clk = ~clk;
  multiboot_icap_ctrl #(.GOLDEN_EN(1'b0), .ICAP_DIV(DIV)) u0 (
    .clk(clk), .rst_n(rst_n), .kb_boot_core(kb), .zxuno_addr(addr), .zxuno_regwr(regwr),
    .zxuno_regrd(regrd), .din(din), .dout(dout0), .oe(oe0), .busy(busy0), .icap_clk(ick0),
    .icap_ce_n(ce0), .icap_wr_n(wr0), .icap_i(i0));
  multiboot_icap_ctrl #(.GOLDEN_EN(1'b1), .GOLDEN_ADDR(24'h058000), .ICAP_DIV(DIV)) u1 (
    .clk(clk), .rst_n(rst_n), .kb_boot_core(kb), .zxuno_addr(addr), .zxuno_regwr(regwr),
    .zxuno_regrd(regrd), .din(din), .dout(dout1), .oe(oe1), .busy(busy1), .icap_clk(ick1),
    .icap_ce_n(ce1), .icap_wr_n(wr1), .icap_i(i1));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  function automatic logic [15:0] sw(input logic [15:0] w);
    logic [7:0] a, b;
    a = {<<{w[15:8]}};
    b = {<<{w[7:0]}};
    return {a, b};
  endfunction
  task automatic push_seq(input logic [23:0] a);
    logic [15:0] h[8], g[4], t[6];
    h = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, a[15:0], 16'h3281, {8'h03, a[23:16]}};
    g = '{16'h32A1, 16'h8000, 16'h32C1, 16'h0305};
    t = '{16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    foreach (h[k]) begin q0.push_back(sw(h[k])); q1.push_back(sw(h[k])); end
    foreach (g[k]) q1.push_back(sw(g[k]));
    foreach (t[k]) begin q0.push_back(sw(t[k])); q1.push_back(sw(t[k])); end
  endtask
  // ICAP samples on icap_clk rising; compare whatever is enabled there.
  always @(posedge ick0) begin
    #1;
    if (!ce0) begin
      if (q0.size() == 0) begin total++; $display("FAIL u0_extra_word: got %h expected none", i0); end
      else begin chk("u0_word", {wr0, i0}, {1'b0, q0.pop_front()}); popped0++; end
    end
  end
  always @(posedge ick1) begin
    #1;
    if (!ce1) begin
      if (q1.size() == 0) begin total++; $display("FAIL u1_extra_word: got %h expected none", i1); end
      else chk("u1_word", {wr1, i1}, {1'b0, q1.pop_front()});
    end
  end
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; din = d; regwr = 1'b1;
    @(negedge clk); regwr = 1'b0;
  endtask
  task automatic rd(input string n, input logic [7:0] a, input logic [7:0] e0, input logic [7:0] e1);
    @(negedge clk); addr = a; regrd = 1'b1;
    #1;
    chk({n, "_u0"}, {oe0, dout0}, {1'b1, e0});
    chk({n, "_u1"}, {oe1, dout1}, {1'b1, e1});
    regrd = 1'b0;
  endtask
  task automatic finish_seq(input string n);
    int k;
    for (k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (!busy0 && !busy1) break;
    end
    chk({n, "_idle"}, {busy0, busy1}, 2'b00);
    repeat (40) @(negedge clk);
    chk({n, "_q0_empty"}, q0.size(), 0);
    chk({n, "_q1_empty"}, q1.size(), 0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int k;
    logic started;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins_u0", {busy0, ick0, ce0, wr0, i0}, {4'b0011, 16'hFFFF});
    chk("rst_pins_u1", {busy1, ick1, ce1, wr1, i1}, {4'b0011, 16'hFFFF});
    chk("rst_no_oe", {oe0, dout0, oe1, dout1}, 18'h0);
    @(negedge clk); rst_n = 1'b1;
    rd("rst_fd", 8'hFD, 8'h00, 8'h01);
    rd("rst_fc", 8'hFC, 8'h00, 8'h00);
    // default-address boot
    push_seq(24'h0AC000);
    wr(8'hFD, 8'h01);
    chk("t1_busy", {busy0, busy1}, 2'b11);
    finish_seq("t1");
    // programmed address, golden words on u1
    wr(8'hFC, 8'h12); wr(8'hFC, 8'h34); wr(8'hFC, 8'h56);
    rd("t2_fc", 8'hFC, 8'h56, 8'h56);
    push_seq(24'h123456);
    wr(8'hFD, 8'h01);
    finish_seq("t2");
    // long strobe shifts once: address becomes 3456AB
    @(negedge clk); addr = 8'hFC; din = 8'hAB; regwr = 1'b1;
    repeat (50) @(negedge clk);
    regwr = 1'b0;
    rd("t3_fc", 8'hFC, 8'hAB, 8'hAB);
    push_seq(24'h3456AB);
    wr(8'hFD, 8'h01);
    // everything during busy must be dropped
    wr(8'hFC, 8'hFF);
    wr(8'hFD, 8'h01);
    kb = 1'b1;
    repeat (6) @(negedge clk);
    kb = 1'b0;
    chk("t4_still_busy", {busy0, busy1}, 2'b11);
    rd("t4_fd_busy", 8'hFD, 8'h80, 8'h81);
    finish_seq("t4");
    rd("t4_fc", 8'hFC, 8'hAB, 8'hAB);
    // keyboard trigger latency and no retrigger on held level
    push_seq(24'h3456AB);
    @(negedge clk); kb = 1'b1;
    started = 1'b0;
    for (k = 0; k < DIV + 3; k++) begin
      @(posedge clk); #1;
      if (!ce0) begin started = 1'b1; break; end
    end
    chk("t5_kb_latency", started, 1'b1);
    finish_seq("t5");
    kb = 1'b0;
    repeat (5) @(negedge clk);
    // reset in the middle of the sequence
    popped0 = 0;
    push_seq(24'h3456AB);
    wr(8'hFD, 8'h01);
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (popped0 >= 6) break;
    end
    chk("t6_reach_word5", popped0 >= 6, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_abort_u0", {ce0, wr0, busy0}, 3'b110);
    chk("t6_abort_u1", {ce1, wr1, busy1}, 3'b110);
    q0.delete(); q1.delete();
    @(negedge clk); rst_n = 1'b1;
    wr(8'hFC, 8'h11); wr(8'hFC, 8'h22); wr(8'hFC, 8'h33);
    push_seq(24'h0AC000);
    wr(8'hFD, 8'h81);
    chk("t6_busy", {busy0, busy1}, 2'b11);
    finish_seq("t6");
    rd("t6_fc", 8'hFC, 8'h00, 8'h00);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
